board_renderer: RTL

BOARD_RENDERER -- requirements
Module: board_renderer

---
 rtl/tetris_pkg.sv | 20 ++
 rtl/pixel_cell_decode.sv | 57 +++++
 rtl/board_renderer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared board geometry, color codes and region encoding for the playfield renderer.
package tetris_pkg;

    localparam int unsigned BOARD_COLS = 10;
    localparam int unsigned BOARD_ROWS = 20;
    localparam int unsigned CELL_PX    = 16;
    localparam int unsigned SCREEN_W   = 640;
    localparam int unsigned SCREEN_H   = 480;

    localparam logic [3:0] COL_BG     = 4'hf;
    localparam logic [3:0] COL_BORDER = 4'hc;
    localparam logic [3:0] COL_GRID   = 4'hd;

    typedef enum logic [1:0] {
        RegOutside,
        RegBorder,
        RegInterior
    } region_e;

endpackage

// File: rtl/pixel_cell_decode.sv
// Combinational map from a screen pixel to its board region, cell and in-cell offset.
module pixel_cell_decode
    import tetris_pkg::*;
#(
    parameter int unsigned ORIGIN_X  = 240,
    parameter int unsigned ORIGIN_Y  = 80,
    parameter int unsigned BORDER_PX = 8
) (
    input  logic [9:0] draw_x_i,
    input  logic [9:0] draw_y_i,
    output region_e    region_o,
    output logic [3:0] col_o,
    output logic [4:0] row_o,
    output logic [3:0] off_x_o,
    output logic [3:0] off_y_o
);

    logic [9:0] rel_x;
    logic [9:0] rel_y;
    logic       on_screen;
    logic       in_x;
    logic       in_y;
    logic       ring_x;
    logic       ring_y;

    assign rel_x = draw_x_i - 10'(ORIGIN_X);
    assign rel_y = draw_y_i - 10'(ORIGIN_Y);

    assign on_screen = (draw_x_i < 10'(SCREEN_W)) && (draw_y_i < 10'(SCREEN_H));

    // Interior test guards against the subtraction wrapping when left of / above the origin.
    assign in_x = (draw_x_i >= 10'(ORIGIN_X)) && (rel_x < 10'(BOARD_COLS * CELL_PX));
    assign in_y = (draw_y_i >= 10'(ORIGIN_Y)) && (rel_y < 10'(BOARD_ROWS * CELL_PX));

    assign ring_x = (({1'b0, draw_x_i} + 11'(BORDER_PX)) >= 11'(ORIGIN_X)) &&
                    ({1'b0, draw_x_i} < 11'(ORIGIN_X + BOARD_COLS * CELL_PX + BORDER_PX));
    assign ring_y = (({1'b0, draw_y_i} + 11'(BORDER_PX)) >= 11'(ORIGIN_Y)) &&
                    ({1'b0, draw_y_i} < 11'(ORIGIN_Y + BOARD_ROWS * CELL_PX + BORDER_PX));

    always_comb begin
        region_o = RegOutside;
        col_o    = '0;
        row_o    = '0;
        off_x_o  = '0;
        off_y_o  = '0;
        if (on_screen && in_x && in_y) begin
            region_o = RegInterior;
            col_o    = rel_x[7:4];
            row_o    = rel_y[8:4];
            off_x_o  = rel_x[3:0];
            off_y_o  = rel_y[3:0];
        end else if (on_screen && ring_x && ring_y) begin
            region_o = RegBorder;
        end
    end

endmodule

// File: rtl/board_renderer.sv
// Two-stage pixel pipeline: decode + RAM address in stage 1, color select in stage 2,
// with the falling piece overlaid from registers latched once per frame.
module board_renderer
    import tetris_pkg::*;
#(
    parameter int unsigned ORIGIN_X  = 240,
    parameter int unsigned ORIGIN_Y  = 80,
    parameter int unsigned BORDER_PX = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        frame_start,
    input  logic [3:0]  piece_x,
    input  logic [4:0]  piece_y,
    input  logic [15:0] piece_mask,
    input  logic [3:0]  piece_color,
    output logic [7:0]  board_addr,
    input  logic [3:0]  board_rdata,
    output logic [3:0]  color
);

    region_e    dec_region;
    logic [3:0] dec_col;
    logic [4:0] dec_row;
    logic [3:0] dec_off_x;
    logic [3:0] dec_off_y;

    pixel_cell_decode #(
        .ORIGIN_X  (ORIGIN_X),
        .ORIGIN_Y  (ORIGIN_Y),
        .BORDER_PX (BORDER_PX)
    ) u_decode (
        .draw_x_i (DrawX),
        .draw_y_i (DrawY),
        .region_o (dec_region),
        .col_o    (dec_col),
        .row_o    (dec_row),
        .off_x_o  (dec_off_x),
        .off_y_o  (dec_off_y)
    );

    logic [3:0]  sh_x_q;
    logic [4:0]  sh_y_q;
    logic [15:0] sh_mask_q;
    logic [3:0]  sh_color_q;

    // Piece state only moves at frame_start so a frame never shows a half-updated piece.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sh_x_q     <= '0;
            sh_y_q     <= '0;
            sh_mask_q  <= '0;
            sh_color_q <= '0;
        end else if (frame_start) begin
            sh_x_q     <= piece_x;
            sh_y_q     <= piece_y;
            sh_mask_q  <= piece_mask;
            sh_color_q <= piece_color;
        end
    end

    logic       cover_d;
    logic [4:0] cell_col;
    logic [5:0] cell_row;

    // Widened sums so a piece hanging off the right or bottom is clipped, not wrapped.
    always_comb begin
        cover_d  = 1'b0;
        cell_col = '0;
        cell_row = '0;
        for (int dy = 0; dy < 4; dy++) begin
            for (int dx = 0; dx < 4; dx++) begin
                cell_col = {1'b0, sh_x_q} + 5'(dx);
                cell_row = {1'b0, sh_y_q} + 6'(dy);
                if (sh_mask_q[4 * dy + dx] &&
                    (cell_col < 5'(BOARD_COLS)) && (cell_row < 6'(BOARD_ROWS)) &&
                    (cell_col == {1'b0, dec_col}) && (cell_row == {1'b0, dec_row})) begin
                    cover_d = 1'b1;
                end
            end
        end
    end

    logic [7:0] addr_d;
    logic       grid_d;

    always_comb begin
        addr_d = '0;
        if (dec_region == RegInterior) begin
            addr_d = ({3'b000, dec_row} << 3) + ({3'b000, dec_row} << 1) + {4'b0000, dec_col};
        end
        grid_d = (dec_off_x == 4'hf) || (dec_off_y == 4'hf);
    end

    region_e region_q;
    logic    grid_q;
    logic    cover_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            region_q   <= RegOutside;
            grid_q     <= 1'b0;
            cover_q    <= 1'b0;
            board_addr <= '0;
        end else begin
            region_q   <= dec_region;
            grid_q     <= grid_d;
            cover_q    <= cover_d && (dec_region == RegInterior);
            board_addr <= addr_d;
        end
    end

    logic [3:0] color_d;

    always_comb begin
        color_d = COL_BG;
        case (region_q)
            RegInterior: begin
                if (grid_q) begin
                    color_d = COL_GRID;
                end else if (cover_q) begin
                    color_d = sh_color_q;
                end else begin
                    color_d = board_rdata;
                end
            end
            RegBorder: color_d = COL_BORDER;
            default:   color_d = COL_BG;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            color <= COL_BG;
        end else begin
            color <= color_d;
        end
    end

endmodule
